// File: rtl/bht_update_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : bht_update_scheduler_if                                |
// | Description : Commit-outcome input channel and BHT update port       |
// |               bundled for the BHT update scheduler.                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface bht_update_scheduler_if #(
  parameter int unsigned IDX_W = 8
);
  // ROB commit side
  logic              commit_valid;
  logic [31:0]       commit_pc;
  logic              commit_taken;
  logic              commit_ready;
  // Soft re-initialisation request
  logic              bht_clear;
  // Predictor update port
  logic              bht_we;
  logic              bht_force;
  logic [IDX_W-1:0]  bht_index;
  logic              bht_taken;
  logic [1:0]        bht_force_val;

  // Requester side (ROB / control)
  modport master (
    output commit_valid, commit_pc, commit_taken, bht_clear,
    input  commit_ready, bht_we, bht_force, bht_index, bht_taken, bht_force_val
  );

  // Scheduler side
  modport slave (
    input  commit_valid, commit_pc, commit_taken, bht_clear,
    output commit_ready, bht_we, bht_force, bht_index, bht_taken, bht_force_val
  );
endinterface
`default_nettype wire

// File: rtl/bht_update_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : bht_update_scheduler                                   |
// | Description : Sole writer of the branch history table. Walks every   |
// |               index with the init value after reset / soft clear,    |
// |               then drains buffered commit outcomes one per cycle.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module bht_update_scheduler #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned IDX_W    = 8,
  parameter logic [1:0]  INIT_VAL = 2'b00
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  bht_update_scheduler_if.slave    bus,
  output logic                     init_busy,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned          C_PTR_W    = $clog2(DEPTH);
  localparam int unsigned          C_CNT_W    = C_PTR_W + 1;
  localparam logic [C_CNT_W-1:0]   C_DEPTH    = C_CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0]     C_LAST_IDX = '1;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e              state_q,     state_d;
  logic [IDX_W-1:0]    init_ctr_q,  init_ctr_d;
  logic                bht_we_q,    bht_we_d;
  logic                bht_force_q, bht_force_d;
  logic [IDX_W-1:0]    bht_index_q, bht_index_d;
  logic                bht_taken_q, bht_taken_d;
  logic [C_CNT_W-1:0]  count_q,     count_d;
  logic [C_PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
  logic [C_PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
  logic [7:0]          drop_cnt_q,  drop_cnt_d;
  logic [IDX_W-1:0]    mem_idx_q   [DEPTH];
  logic [IDX_W-1:0]    mem_idx_d   [DEPTH];
  logic [DEPTH-1:0]    mem_taken_q, mem_taken_d;

  logic                w_commit_ready;
  logic                w_push;
  logic                w_drop;
  logic                w_clear;
  logic                w_pop;
  logic [IDX_W-1:0]    w_commit_idx;
  logic                unused_pc_bits;

  // Low two PC bits and everything above the index field do not select an entry
  assign w_commit_idx   = bus.commit_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{bus.commit_pc[31:IDX_W+2], bus.commit_pc[1:0]};

  // Handshake qualifiers; every state change is gated by rdy so a low rdy freezes all
  assign w_commit_ready = (count_q < C_DEPTH);
  assign w_push         = rdy & bus.commit_valid & w_commit_ready;
  assign w_drop         = rdy & bus.commit_valid & ~w_commit_ready;
  assign w_clear        = rdy & bus.bht_clear;
  // A clear wins over a drain so queued outcomes survive until after the walk
  assign w_pop          = rdy & ~w_clear & (state_q == ST_RUN) & (count_q != '0);

  // Next-state logic for the init/run sequencer, the FIFO and the drop counter
  always_comb begin
    state_d     = state_q;
    init_ctr_d  = init_ctr_q;
    bht_we_d    = bht_we_q;
    bht_force_d = bht_force_q;
    bht_index_d = bht_index_q;
    bht_taken_d = bht_taken_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    drop_cnt_d  = drop_cnt_q;
    mem_idx_d   = mem_idx_q;
    mem_taken_d = mem_taken_q;

    if (rdy) begin
      case (state_q)
        ST_INIT: begin
          if (bus.bht_clear) begin
            init_ctr_d  = '0;
            bht_we_d    = 1'b0;
            bht_force_d = 1'b0;
          end else begin
            bht_we_d    = 1'b1;
            bht_force_d = 1'b1;
            bht_index_d = init_ctr_q;
            bht_taken_d = 1'b0;
            init_ctr_d  = init_ctr_q + 1'b1;
            if (init_ctr_q == C_LAST_IDX) begin
              state_d    = ST_RUN;
              init_ctr_d = '0;
            end
          end
        end
        ST_RUN: begin
          if (bus.bht_clear) begin
            state_d     = ST_INIT;
            init_ctr_d  = '0;
            bht_we_d    = 1'b0;
            bht_force_d = 1'b0;
          end else if (w_pop) begin
            bht_we_d    = 1'b1;
            bht_force_d = 1'b0;
            bht_index_d = mem_idx_q[rd_ptr_q];
            bht_taken_d = mem_taken_q[rd_ptr_q];
          end else begin
            bht_we_d    = 1'b0;
            bht_force_d = 1'b0;
          end
        end
        default: begin
          state_d    = ST_INIT;
          init_ctr_d = '0;
        end
      endcase
    end

    if (w_push) begin
      mem_idx_d[wr_ptr_q]   = w_commit_idx;
      mem_taken_d[wr_ptr_q] = bus.commit_taken;
      wr_ptr_d              = wr_ptr_q + C_PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + C_CNT_W'(1);
      2'b01:   count_d = count_q - C_CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (w_drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // State registers; reset discards any queued outcomes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_ctr_q  <= '0;
      bht_we_q    <= 1'b0;
      bht_force_q <= 1'b0;
      bht_index_q <= '0;
      bht_taken_q <= 1'b0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      drop_cnt_q  <= '0;
      mem_idx_q   <= '{default: '0};
      mem_taken_q <= '0;
    end else begin
      state_q     <= state_d;
      init_ctr_q  <= init_ctr_d;
      bht_we_q    <= bht_we_d;
      bht_force_q <= bht_force_d;
      bht_index_q <= bht_index_d;
      bht_taken_q <= bht_taken_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      drop_cnt_q  <= drop_cnt_d;
      mem_idx_q   <= mem_idx_d;
      mem_taken_q <= mem_taken_d;
    end
  end

  assign bus.commit_ready  = w_commit_ready;
  assign bus.bht_we        = bht_we_q;
  assign bus.bht_force     = bht_force_q;
  assign bus.bht_index     = bht_index_q;
  assign bus.bht_taken     = bht_taken_q;
  assign bus.bht_force_val = INIT_VAL;
  assign init_busy         = (state_q == ST_INIT);
  assign q_count           = count_q;
  assign drop_cnt          = drop_cnt_q;

endmodule
`default_nettype wire

// File: doc/bht_update_scheduler.md
# bht_update_scheduler

Sequences all writes into the branch history table (BHT) of the issue-stage branch predictor. After reset, and on a soft clear, it walks every BHT index and force-writes the initial counter value. In normal operation it buffers resolved-branch outcomes from ROB commit in a small FIFO and drains them at one training write per cycle. It is the only block that drives the predictor's update port.

## Interface
Parameters:
- DEPTH, 4: commit-outcome FIFO entries; power of two, at least 2.
- IDX_W, 8: BHT index width (table size 2^IDX_W).
- INIT_VAL, 2'b00: counter value force-written during the init walk (strong not-taken).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- rdy  in  1  global ready; when low, all state freezes.
- commit_valid  in  1  ROB commits a resolved conditional branch this cycle.
- commit_pc  in  32  PC of the committed branch.
- commit_taken  in  1  resolved direction (1 = taken).
- commit_ready  out  1  FIFO can accept; equals count < DEPTH from the registered count.
- bht_clear  in  1  one-cycle request to re-initialise the BHT.
- bht_we  out  1  BHT write strobe (registered).
- bht_force  out  1  1 = write bht_force_val directly; 0 = train the 2-bit counter with bht_taken.
- bht_index  out  IDX_W  table index.
- bht_taken  out  1  training direction.
- bht_force_val  out  2  constant INIT_VAL.
- init_busy  out  1  high while in INIT.
- q_count  out  clog2(DEPTH)+1  FIFO occupancy.
- drop_cnt  out  8  saturating count of commits lost to a full FIFO.

## Operation
- Index mapping: index = commit_pc[IDX_W+1:2]; the low 2 PC bits are ignored.
- The FSM has two states, INIT and RUN.
- INIT:
  - Each rdy cycle: bht_we=1, bht_force=1, bht_index=init_ctr, then init_ctr++.
  - The edge that emits index 2^IDX_W-1 moves the FSM to RUN and clears init_ctr.
  - The FIFO accepts commits but does not drain.
- RUN:
  - Each rdy cycle with count>0: pop the head; bht_we=1, bht_force=0, index and taken taken from the head.
  - When count=0: bht_we=0.
- bht_clear in RUN: next state INIT, init_ctr=0. FIFO contents are kept and drained after the walk.
- bht_clear in INIT: restarts the walk at index 0.
- Push rule:
  - A push occurs when commit_valid && commit_ready && rdy.
  - If commit_valid && !commit_ready && rdy: the commit is dropped and drop_cnt++ (saturates at 255).
  - A push and a pop in the same cycle: count is unchanged and order is preserved.
  - When full, a commit is dropped even if a pop occurs in the same cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- rdy low: FSM, pointers, counters and all output registers hold. bht_we stays at its value, and the BHT gates its write with rdy, so no duplicate write occurs.

## Timing
- Reset values: state=INIT, init_ctr=0, bht_we=0, bht_force=0, bht_index=0, bht_taken=0, count=0, drop_cnt=0. init_busy=1, commit_ready=1.
- After rst deasserts, the first rdy edge emits index 0. The 2^IDX_W-th edge emits the last index. init_busy falls after that edge.
- Commit latency: commit accepted at edge E into an empty FIFO in RUN; bht_we=1 for it after edge E+1. There is no bypass.
- Throughput: one BHT write per rdy cycle.
- A rst assertion mid-walk or mid-drain immediately returns all registers to their reset values, and FIFO contents are lost.
- bht_clear takes effect at the edge where it is sampled. A pop already registered in that cycle's outputs completes normally.

## Test plan
- Reset release with rdy=1 held: exactly 256 consecutive bht_we/bht_force pulses at indices 0..255. init_busy falls after the 256th. No further bht_we.
- In RUN, commit pc=0x0000_1084 taken: one cycle later bht_we=1, bht_force=0, bht_index=0x21, bht_taken=1, then bht_we=0.
- Commit 4 branches back-to-back during INIT (FIFO fills, commit_ready=0), and a 5th commit is dropped (drop_cnt=1). After the walk the 4 outcomes drain in order over 4 cycles.
- Continuous commits every cycle in RUN: q_count stays at 1, no drops, each outcome is written exactly once in order across pointer wrap (≥10 commits).
- rdy low for 3 cycles mid-walk at index 0x40: outputs are frozen. On resume, indexes continue at 0x41 with no skipped or repeated index.
- bht_clear in RUN with 2 queued commits: walk restarts at index 0. The 2 commits are written after index 255, and drop_cnt is unchanged.
